// File: rtl/lifo_stack_rf.sv
// lifo_stack_rf: parametrised LIFO stack held in a pointer-addressed register
// file. Only one entry is written per cycle; the top of stack is mem[count-1].
// Supports an occupancy count, an almost-full threshold, synchronous flush,
// and replace-top when push and pop arrive together.
//
// Handshake: push/pop/flush are level requests sampled on every rising edge.
// There is no ready signal. The producer watches full and the consumer watches
// val to know whether a request will take effect. A request that cannot take
// effect is dropped, and it is recorded as an overflow or underflow event.
//
// Build option: define LIFO_STACK_ERR_EN to get sticky ovf/udf flags.
// Without it, ovf and udf are tied to 0. The port list is the same in both builds.
module lifo_stack_rf #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH) + 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              val,
  output logic              full,
  output logic              afull,
  output logic [CW-1:0]     count,
  output logic              ovf,
  output logic              udf
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     top_idx;

  // Status flags are pure functions of the occupancy count.
  assign val     = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign afull   = (count_q >= CW'(AFULL_LVL));
  assign count   = count_q;
  assign top_idx = AW'(count_q - CW'(1));

  // The top of stack is read combinationally. It reads as zero when the stack is empty.
  always_comb begin
    data_out = '0;
    if (val) data_out = mem_q[top_idx];
  end

  // Next count and write port. Priority: flush > push&pop > push > pop.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = AW'(count_q);
    if (flush) begin
      count_d = '0;
    end else if (push && pop && val) begin
      // Replace-top: overwrite in place. The depth does not change, even when full.
      wr_en   = 1'b1;
      wr_addr = top_idx;
    end else if (push && !full) begin
      // Covers push&pop on an empty stack too, which acts as a plain push.
      wr_en   = 1'b1;
      count_d = count_q + CW'(1);
    end else if (pop && !push && val) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state. Reset aborts any pending operation and empties the stack logically.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Data storage is never reset. Stale entries are unreachable once count moves below them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= data_in;
  end

`ifdef LIFO_STACK_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky error flags. They set on a dropped push or pop and clear on flush.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (push && !pop && full) ovf_d = 1'b1;
      if (pop && !push && !val) udf_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
